// File: rtl/uart_loader_if.sv
// uart_loader_if: loader-to-core bundle; master = loader (rx, skip in; uart_data, uart_addr, uart_done, word_strobe, frame_err out), slave = core/driver side
interface uart_loader_if;
  logic rx;
  logic skip;
  logic [31:0] uart_data;
  logic [31:0] uart_addr;
  logic uart_done;
  logic word_strobe;
  logic frame_err;
  modport master(input rx, skip, output uart_data, uart_addr, uart_done, word_strobe, frame_err);
  modport slave(output rx, skip, input uart_data, uart_addr, uart_done, word_strobe, frame_err);
endinterface

// File: rtl/uart_loader.sv
// uart_loader: 8N1 UART receiver packing bytes little-endian into 32-bit words for memory port B; ports clk, rst, bus (uart_loader_if.master); optional idle timeout via UART_LOADER_TIMEOUT_EN
module uart_loader #(
`ifdef UART_LOADER_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CLKS = 2_500_000,
`endif
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned WORD_COUNT = 16384,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input logic clk,
  input logic rst,
  uart_loader_if.master bus
);
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int WW = $clog2(WORD_COUNT + 1);
  logic rx_m_q, rx_s_q;
  logic [1:0] st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic [1:0] bi_q, bi_d;
  logic [WW-1:0] wi_q, wi_d;
  logic [23:0] w_q, w_d;
  logic [31:0] data_q, data_d, addr_q, addr_d;
  logic done_q, done_d, stb_q, stb_d, ferr_q, ferr_d;
  logic [1:0] dr_q, dr_d;
  logic half, full_bit, bv, full, fin, tout;
  assign half = cnt_q == CW'(CLKS_PER_BIT / 2 - 1);
  assign full_bit = cnt_q == CW'(CLKS_PER_BIT - 1);
  assign full = wi_q == WW'(WORD_COUNT);
  assign fin = full || tout;
  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q + 1'b1;
    bit_d = bit_q;
    sh_d = sh_q;
    bv = 1'b0;
    ferr_d = 1'b0;
    case (st_q)
      IDLE: begin
        cnt_d = '0;
        st_d = rx_s_q ? IDLE : START;
      end
      START: if (half) begin
        cnt_d = '0;
        bit_d = '0;
        st_d = rx_s_q ? IDLE : DATA;
      end
      DATA: if (full_bit) begin
        cnt_d = '0;
        sh_d = {rx_s_q, sh_q[7:1]};
        bit_d = bit_q + 1'b1;
        st_d = bit_q == 3'd7 ? STOP : DATA;
      end
      default: if (full_bit) begin
        cnt_d = '0;
        st_d = IDLE;
        bv = rx_s_q && !done_q;
        ferr_d = !rx_s_q && !done_q;
      end
    endcase
    if (done_q) st_d = IDLE;
  end
  always_comb begin
    bi_d = bi_q;
    wi_d = wi_q;
    w_d = w_q;
    data_d = data_q;
    addr_d = addr_q;
    stb_d = 1'b0;
    if (bv && !full) begin
      if (bi_q == 2'd3) begin
        data_d = {sh_q, w_q};
        addr_d = BASE_ADDR + (32'(wi_q) << 2);
        stb_d = 1'b1;
        wi_d = wi_q + 1'b1;
        bi_d = '0;
      end else begin
        w_d = {sh_q, w_q[23:8]};
        bi_d = bi_q + 1'b1;
      end
    end
    if (tout) bi_d = '0;
    dr_d = (!done_q && (fin || dr_q != 2'd0)) ? dr_q + 2'd1 : dr_q;
    done_d = done_q || bus.skip || dr_q == 2'd1;
  end
`ifdef UART_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  logic [TW-1:0] idle_q;
  logic got_q;
  assign tout = idle_q == TW'(TIMEOUT_CLKS);
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q <= '0;
      got_q <= 1'b0;
    end else begin
      got_q <= got_q || bv;
      idle_q <= (st_q != IDLE || !rx_s_q) ? '0 : (got_q && !tout) ? idle_q + 1'b1 : idle_q;
    end
  end
`else
  assign tout = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
      st_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      bi_q <= '0;
      wi_q <= '0;
      w_q <= '0;
      data_q <= '0;
      addr_q <= BASE_ADDR;
      done_q <= 1'b0;
      stb_q <= 1'b0;
      ferr_q <= 1'b0;
      dr_q <= '0;
    end else begin
      rx_m_q <= bus.rx;
      rx_s_q <= rx_m_q;
      st_q <= st_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      bi_q <= bi_d;
      wi_q <= wi_d;
      w_q <= w_d;
      data_q <= data_d;
      addr_q <= addr_d;
      done_q <= done_d;
      stb_q <= stb_d;
      ferr_q <= ferr_d;
      dr_q <= dr_d;
    end
  end
  assign bus.uart_data = data_q;
  assign bus.uart_addr = addr_q;
  assign bus.uart_done = done_q;
  assign bus.word_strobe = stb_q;
  assign bus.frame_err = ferr_q;
endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: directed and random UART frames against a byte-to-word reference model
module tb_uart_loader;
  localparam int CPB = 8;
  localparam int WC = 2;
  localparam logic [31:0] BASE = 32'h1000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx = 1'b1;
  logic skip = 1'b0;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int stb_cnt, ferr_cnt, stb_cyc, done_cyc;
  logic [7:0] mb[$];
  int mwi;
  logic mdone;
  logic [31:0] exp_data, exp_addr;
  logic [7:0] r;
  uart_loader_if bus();
  assign bus.rx = rx;
  assign bus.skip = skip;
  uart_loader #(.CLKS_PER_BIT(CPB), .WORD_COUNT(WC), .BASE_ADDR(BASE)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rst) begin
      stb_cnt <= 0;
      ferr_cnt <= 0;
      stb_cyc <= -1;
      done_cyc <= -1;
    end else begin
      if (bus.word_strobe) begin
        stb_cnt <= stb_cnt + 1;
        stb_cyc <= cyc;
      end
      if (bus.frame_err) ferr_cnt <= ferr_cnt + 1;
      if (bus.uart_done && done_cyc < 0) done_cyc <= cyc;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    rx = 1'b1;
    skip = 1'b0;
    idle(4);
    rst = 1'b0;
    mb.delete();
    mwi = 0;
    mdone = 1'b0;
    exp_data = '0;
    exp_addr = BASE;
    idle(2);
  endtask
  task automatic send(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(CPB);
    end
    rx = stop;
    idle(CPB);
    rx = 1'b1;
    if (stop && !mdone) begin
      mb.push_back(b);
      if (mb.size() == 4) begin
        exp_data = {mb[3], mb[2], mb[1], mb[0]};
        exp_addr = BASE + 32'(mwi) * 4;
        mwi++;
        mb.delete();
        if (mwi == WC) mdone = 1'b1;
      end
    end
  endtask
  task automatic check_words(input string tag);
    idle(4);
    chk({tag, "_strobes"}, 32'(stb_cnt), 32'(mwi));
    chk({tag, "_data"}, bus.uart_data, exp_data);
    chk({tag, "_addr"}, bus.uart_addr, exp_addr);
    chk({tag, "_done"}, {31'b0, bus.uart_done}, {31'b0, mdone});
  endtask
  initial begin
    do_reset();
    idle(20);
    chk("rst_data", bus.uart_data, 32'h0);
    chk("rst_addr", bus.uart_addr, BASE);
    chk("rst_done", {31'b0, bus.uart_done}, 32'h0);
    chk("rst_strobe", 32'(stb_cnt), 32'h0);
    chk("rst_ferr", {31'b0, bus.frame_err}, 32'h0);
    send(8'h78, 1'b1);
    send(8'h56, 1'b1);
    send(8'h34, 1'b1);
    send(8'h12, 1'b1);
    check_words("w0");
    chk("w0_const", bus.uart_data, 32'h12345678);
    send(8'hEF, 1'b1);
    send(8'hBE, 1'b1);
    send(8'hAD, 1'b1);
    send(8'hDE, 1'b1);
    check_words("w1");
    chk("w1_const", bus.uart_data, 32'hDEADBEEF);
    chk("w1_addr_const", bus.uart_addr, 32'h1004);
    chk("done_delay", 32'(done_cyc - stb_cyc), 32'd2);
    send(8'($urandom_range(0, 255)), 1'b1);
    send(8'($urandom_range(0, 255)), 1'b1);
    check_words("post_done");
    do_reset();
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(20);
    chk("glitch_strobe", 32'(stb_cnt), 32'h0);
    chk("glitch_ferr", 32'(ferr_cnt), 32'h0);
    send(8'hAA, 1'b1);
    for (int i = 0; i < 3; i++) send(8'($urandom_range(0, 255)), 1'b1);
    check_words("glitch_word");
    chk("glitch_low_byte", {24'b0, bus.uart_data[7:0]}, 32'hAA);
    do_reset();
    send(8'($urandom_range(0, 255)), 1'b0);
    idle(2 * CPB);
    chk("ferr_count", 32'(ferr_cnt), 32'd1);
    chk("ferr_strobe", 32'(stb_cnt), 32'h0);
    for (int i = 0; i < 4; i++) send(8'($urandom_range(0, 255)), 1'b1);
    check_words("ferr_word");
    do_reset();
    send(8'($urandom_range(0, 255)), 1'b1);
    send(8'($urandom_range(0, 255)), 1'b1);
    idle(3);
    chk("skip_pre_done", {31'b0, bus.uart_done}, 32'h0);
    skip = 1'b1;
    idle(1);
    chk("skip_done", {31'b0, bus.uart_done}, 32'h1);
    skip = 1'b0;
    mdone = 1'b1;
    mb.delete();
    idle(5);
    chk("skip_strobe", 32'(stb_cnt), 32'h0);
    chk("skip_sticky", {31'b0, bus.uart_done}, 32'h1);
    do_reset();
    send(8'($urandom_range(0, 255)), 1'b1);
    send(8'($urandom_range(0, 255)), 1'b1);
    do_reset();
    for (int w = 0; w < WC; w++) begin
      for (int i = 0; i < 4; i++) begin
        r = 8'($urandom_range(0, 255));
        send(r, 1'b1);
        idle($urandom_range(0, 3));
      end
      check_words("rand");
    end
    chk("rand_done_delay", 32'(done_cyc - stb_cyc), 32'd2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_loader.md
# uart_loader

Serial program loader feeding the CPU's UART memory port. Receives 8N1 bytes on `rx` and packs them little-endian into 32-bit words. Drives `uart_data`, `uart_addr` and `uart_done` into the core, which writes port B of unified memory while `uart_done` is low and holds the pipeline in reset. Raises `uart_done` once the image is complete, releasing the CPU.

## Interface
- `CLKS_PER_BIT`, 217: clock cycles per UART bit (25 MHz / 115200); must be ≥ 4.
- `WORD_COUNT`, 16384: number of words in a full image.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0.
- `TIMEOUT_CLKS`, 2_500_000: idle cycles ending a short image (only with `UART_LOADER_TIMEOUT_EN`).
- `clk  in  1  system clock; one clock, all logic on rising edge`
- `rst  in  1  synchronous, active-high reset`
- `rx  in  1  asynchronous UART line, idle high`
- `skip  in  1  level; forces load complete (boot resident image)`
- `uart_data  out  32  assembled word`
- `uart_addr  out  32  byte address of uart_data`
- `uart_done  out  1  0 = loading (CPU held), 1 = load complete; sticky`
- `word_strobe  out  1  one-cycle pulse when a new word/address is presented`
- `frame_err  out  1  one-cycle pulse on bad stop bit`

## Operation
- `rx` passes through a 2-flop synchronizer; the FSM sees only the synchronized `rx_s`.
- RX FSM states:
  - IDLE: on `rx_s`=0 go to START, clear the counter.
  - START: at count `CLKS_PER_BIT/2 - 1`, go to DATA if `rx_s`=0, else IDLE (glitch rejected).
  - DATA: sample every `CLKS_PER_BIT` cycles, LSB first. After 8 bits go to STOP.
  - STOP: sample after `CLKS_PER_BIT`. If 1, emit byte_valid. If 0, pulse `frame_err` and discard the byte. Return to IDLE in both cases.
- Packer: 2-bit byte index `bi` and word index `wi`. Byte k lands in shift bits [8k+7:8k].
- On byte_valid with `bi`=3, in the same cycle:
  - `uart_data` ← full word.
  - `uart_addr` ← `BASE_ADDR + 4*wi` (32-bit wrap).
  - `word_strobe` pulses, `wi++`, and `bi` wraps to 0.
- `uart_data` and `uart_addr` hold between words. Repeated port-B writes of the same word are harmless.
- Completion: when `wi` reaches `WORD_COUNT`, run a 2-cycle drain so memory captures the last word, then set `uart_done`=1.
- After completion, `rx` activity is ignored and `uart_done` stays 1 until `rst`.
- `skip`=1 in any state sets `uart_done`=1 on the next edge; the partial word is dropped.
- Simultaneous `skip` and final word: `uart_done` is set next cycle and `word_strobe` still pulses.

## Timing
- Reset values: `uart_data`=0, `uart_addr`=`BASE_ADDR`, `uart_done`=0, `word_strobe`=0, `frame_err`=0, FSM=IDLE, `bi`=0, `wi`=0.
- `rst` mid-byte or mid-word aborts everything. The next frame starts a fresh image at `BASE_ADDR`.
- Latency: `rx` edge to FSM = 2 cycles.
- The stop sample falls 9.5 bit times after the start edge. `word_strobe` is registered 1 cycle after that stop sample.
- `uart_done` rises exactly 2 cycles after the final `word_strobe`.
- Back-to-back frames are accepted: IDLE re-arms on the cycle after STOP.

## Configuration
- `UART_LOADER_TIMEOUT_EN` defined:
  - An idle counter runs in IDLE once ≥1 byte has been received.
  - It reaches `TIMEOUT_CLKS` → pending partial word (`bi`≠0) is discarded → `uart_done`=1 after the same 2-cycle drain.
  - Any start bit clears the counter.
- Not defined: no counter; completion only via `WORD_COUNT` or `skip`.

## Test plan
Bench uses `CLKS_PER_BIT`=8, `WORD_COUNT`=2, `BASE_ADDR`=32'h1000.
- Reset, `rx`=1 → all outputs at reset values, `uart_done`=0 indefinitely.
- Bytes 78 56 34 12 → one `word_strobe`, `uart_data`=32'h12345678, `uart_addr`=32'h1000, `uart_done`=0.
- Then bytes EF BE AD DE → `uart_data`=32'hDEADBEEF, `uart_addr`=32'h1004, `uart_done`=1 exactly 2 cycles after that strobe. Further bytes cause no strobe.
- 3-cycle low glitch on `rx` → no byte. A following byte AA is received correctly with `bi`=1.
- Frame with stop bit 0 → `frame_err` pulse, no byte counted. The next 4 valid bytes form word 0 at 32'h1000.
- `skip` pulse after 2 bytes → `uart_done`=1 next cycle, no `word_strobe`. With `UART_LOADER_TIMEOUT_EN` and `TIMEOUT_CLKS`=100: 1 word then idle → `uart_done`=1 at 100+2 cycles.
